// File: rtl/reorder_buffer_pkg.sv
// Shared sizing, entry-type encodings and the per-entry record for the reorder buffer.
// Imported by the interface, the pointer controller and the top.
package rob_pkg;
    localparam int ROB_SIZE = 16;
    localparam int TAG_W    = 4;

    localparam logic [1:0] ROB_T_REG    = 2'd0;
    localparam logic [1:0] ROB_T_STORE  = 2'd1;
    localparam logic [1:0] ROB_T_BRANCH = 2'd2;
    localparam logic [1:0] ROB_T_OTHER  = 2'd3;

    typedef struct packed {
        logic        busy;
        logic        ready;
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic [31:0] value;
        logic        mispredict;
        logic [31:0] next_pc;
    } rob_entry_t;
endpackage

// File: rtl/reorder_buffer_if.sv
// Issue / CDB / commit bundle between the core and the reorder buffer.
// Optional ROB_QUERY_EN adds two operand-query ports for rename.
interface reorder_buffer_if;
    import rob_pkg::*;

    logic             rdy;
    logic             issue_valid;
    logic [1:0]       issue_type;
    logic [4:0]       issue_rd;
    logic [TAG_W-1:0] issue_tag;
    logic             rob_full;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;
    logic             cdb_mispredict;
    logic [31:0]      cdb_next_pc;
    logic             register_update_flag;
    logic [4:0]       register_commit_dest;
    logic [31:0]      register_commit_value;
    logic [TAG_W-1:0] rename_of_commit_ins;
    logic             store_commit_valid;
    logic [TAG_W-1:0] store_commit_tag;
    logic             rob_flush;
    logic [31:0]      flush_pc;
`ifdef ROB_QUERY_EN
    logic [TAG_W-1:0] q1_tag;
    logic [TAG_W-1:0] q2_tag;
    logic             q1_ready;
    logic [31:0]      q1_value;
    logic             q2_ready;
    logic [31:0]      q2_value;
`endif

    modport master (
        output rdy, issue_valid, issue_type, issue_rd,
        output cdb_valid, cdb_tag, cdb_value, cdb_mispredict, cdb_next_pc,
`ifdef ROB_QUERY_EN
        output q1_tag, q2_tag,
        input  q1_ready, q1_value, q2_ready, q2_value,
`endif
        input  issue_tag, rob_full,
        input  register_update_flag, register_commit_dest, register_commit_value,
        input  rename_of_commit_ins, store_commit_valid, store_commit_tag,
        input  rob_flush, flush_pc
    );

    modport slave (
        input  rdy, issue_valid, issue_type, issue_rd,
        input  cdb_valid, cdb_tag, cdb_value, cdb_mispredict, cdb_next_pc,
`ifdef ROB_QUERY_EN
        input  q1_tag, q2_tag,
        output q1_ready, q1_value, q2_ready, q2_value,
`endif
        output issue_tag, rob_full,
        output register_update_flag, register_commit_dest, register_commit_value,
        output rename_of_commit_ins, store_commit_valid, store_commit_tag,
        output rob_flush, flush_pc
    );
endinterface

// File: rtl/reorder_buffer_pointer_ctrl.sv
// Head/tail/count registers of the reorder buffer; full/empty derived from count.
// Latency: pointers move on the edge of the alloc/retire; flush zeroes them in one edge.
// Backpressure: none here; callers gate i_alloc with o_full.
module rob_pointer_ctrl
    import rob_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_alloc,
    input  logic             i_retire,
    input  logic             i_flush,
    output logic [TAG_W-1:0] o_head,
    output logic [TAG_W-1:0] o_tail,
    output logic [TAG_W:0]   o_count,
    output logic             o_full,
    output logic             o_empty
);
    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [TAG_W:0]   r_count;

    // Pointers are exactly TAG_W wide so the increment wraps at ROB_SIZE for free.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_alloc)
                r_tail <= r_tail + TAG_W'(1);
            if (i_retire)
                r_head <= r_head + TAG_W'(1);
            unique case ({i_alloc, i_retire})
                2'b10:   r_count <= r_count + (TAG_W+1)'(1);
                2'b01:   r_count <= r_count - (TAG_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_tail  = r_tail;
    assign o_count = r_count;
    assign o_full  = (r_count == (TAG_W+1)'(ROB_SIZE));
    assign o_empty = (r_count == '0);
endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates on issue, captures CDB results, retires one ready head per cycle.
// Latency: commit pulses are registered, one edge after the head becomes ready; optional ROB_QUERY_EN query ports.
// Backpressure: rob_full stalls the issuer; rdy low freezes all state and outputs.
module reorder_buffer
    import rob_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    reorder_buffer_if.slave  bus
);
    rob_entry_t       r_ent [ROB_SIZE];

    logic             r_reg_upd;
    logic [4:0]       r_reg_dest;
    logic [31:0]      r_reg_val;
    logic [TAG_W-1:0] r_rename;
    logic             r_st_vld;
    logic [TAG_W-1:0] r_st_tag;
    logic             r_flush;
    logic [31:0]      r_flush_pc;

    logic [TAG_W-1:0] w_head;
    logic [TAG_W-1:0] w_tail;
    logic [TAG_W:0]   w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_alloc;
    logic             w_wb;
    logic             w_retire;
    logic             w_flush;
    rob_entry_t       w_head_ent;

    assign w_head_ent = r_ent[w_head];

    // The cycle carrying the flush pulse is dead for issue and writeback.
    assign w_alloc  = bus.rdy && bus.issue_valid && !w_full && !r_flush;
    assign w_wb     = bus.rdy && bus.cdb_valid && !r_flush && r_ent[bus.cdb_tag].busy;
    assign w_retire = bus.rdy && !w_empty && w_head_ent.busy && w_head_ent.ready;
    assign w_flush  = w_retire && (w_head_ent.typ == ROB_T_BRANCH) && w_head_ent.mispredict;

    rob_pointer_ctrl u_ptr (
        .clk      (clk),
        .rst      (rst),
        .i_alloc  (w_alloc),
        .i_retire (w_retire),
        .i_flush  (w_flush),
        .o_head   (w_head),
        .o_tail   (w_tail),
        .o_count  (w_count),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_SIZE; i++)
                r_ent[i] <= '0;
        end else if (w_flush) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                r_ent[i].busy  <= 1'b0;
                r_ent[i].ready <= 1'b0;
            end
        end else begin
            if (w_wb) begin
                r_ent[bus.cdb_tag].ready      <= 1'b1;
                r_ent[bus.cdb_tag].value      <= bus.cdb_value;
                r_ent[bus.cdb_tag].mispredict <= bus.cdb_mispredict;
                r_ent[bus.cdb_tag].next_pc    <= bus.cdb_next_pc;
            end
            if (w_alloc) begin
                r_ent[w_tail].busy  <= 1'b1;
                r_ent[w_tail].ready <= 1'b0;
                r_ent[w_tail].typ   <= bus.issue_type;
                r_ent[w_tail].rd    <= bus.issue_rd;
            end
            if (w_retire)
                r_ent[w_head].busy <= 1'b0;
        end
    end

    // Commit outputs are single-cycle pulses; with rdy low they hold, as downstream is frozen too.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_upd  <= 1'b0;
            r_reg_dest <= '0;
            r_reg_val  <= '0;
            r_rename   <= '0;
            r_st_vld   <= 1'b0;
            r_st_tag   <= '0;
            r_flush    <= 1'b0;
            r_flush_pc <= '0;
        end else if (bus.rdy) begin
            r_reg_upd  <= 1'b0;
            r_reg_dest <= '0;
            r_reg_val  <= '0;
            r_rename   <= '0;
            r_st_vld   <= 1'b0;
            r_st_tag   <= '0;
            r_flush    <= 1'b0;
            r_flush_pc <= '0;
            if (w_retire) begin
                unique case (w_head_ent.typ)
                    ROB_T_REG: begin
                        r_reg_upd  <= (w_head_ent.rd != 5'd0);
                        r_reg_dest <= w_head_ent.rd;
                        r_reg_val  <= w_head_ent.value;
                        r_rename   <= w_head;
                    end
                    ROB_T_STORE: begin
                        r_st_vld <= 1'b1;
                        r_st_tag <= w_head;
                    end
                    ROB_T_BRANCH: begin
                        r_flush    <= w_head_ent.mispredict;
                        r_flush_pc <= w_head_ent.mispredict ? w_head_ent.next_pc : 32'd0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.issue_tag             = w_tail;
    assign bus.rob_full              = w_full;
    assign bus.register_update_flag  = r_reg_upd;
    assign bus.register_commit_dest  = r_reg_dest;
    assign bus.register_commit_value = r_reg_val;
    assign bus.rename_of_commit_ins  = r_rename;
    assign bus.store_commit_valid    = r_st_vld;
    assign bus.store_commit_tag      = r_st_tag;
    assign bus.rob_flush             = r_flush;
    assign bus.flush_pc              = r_flush_pc;

`ifdef ROB_QUERY_EN
    logic w_q1_fwd;
    logic w_q2_fwd;
    assign w_q1_fwd     = w_wb && (bus.cdb_tag == bus.q1_tag);
    assign w_q2_fwd     = w_wb && (bus.cdb_tag == bus.q2_tag);
    assign bus.q1_ready = w_q1_fwd || (r_ent[bus.q1_tag].busy && r_ent[bus.q1_tag].ready);
    assign bus.q1_value = w_q1_fwd ? bus.cdb_value : r_ent[bus.q1_tag].value;
    assign bus.q2_ready = w_q2_fwd || (r_ent[bus.q2_tag].busy && r_ent[bus.q2_tag].ready);
    assign bus.q2_value = w_q2_fwd ? bus.cdb_value : r_ent[bus.q2_tag].value;
`endif
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement buffer for the Tomasulo core. Each entry's index is the 4-bit rename tag that the rename/register stage records per destination register.
- Allocates one entry per issued instruction and captures results broadcast on the CDB.
- Retires one ready head entry per cycle. Retirement drives the register-file commit port (update flag, dest, value, rename tag) and the store-commit port.
- Resolves branch mispredictions at commit by raising a one-cycle flush with the corrected PC.

Parameters:
- ROB_SIZE, 16, number of entries; must be a power of two.
- TAG_W, 4, entry index / rename tag width; equals log2(ROB_SIZE).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when low, all state and outputs hold
- issue_valid  in  1  allocate an entry this cycle
- issue_type  in  2  entry type: 0 = register write, 1 = store, 2 = branch, 3 = other (no destination)
- issue_rd  in  5  destination register (type 0 only)
- issue_tag  out  TAG_W  combinational; equals the tail pointer; the tag assigned to the issuing instruction
- rob_full  out  1  combinational; count == ROB_SIZE
- cdb_valid  in  1  result broadcast
- cdb_tag  in  TAG_W  entry being completed
- cdb_value  in  32  result value
- cdb_mispredict  in  1  branch outcome differs from its prediction
- cdb_next_pc  in  32  correct next PC for a branch
- register_update_flag  out  1  register-file write pulse
- register_commit_dest  out  5  destination register of the retiring entry
- register_commit_value  out  32  value written
- rename_of_commit_ins  out  TAG_W  tag of the retiring entry
- store_commit_valid  out  1  store retiring; the memory unit may perform it
- store_commit_tag  out  TAG_W  tag of the retiring store
- rob_flush  out  1  misprediction flush pulse to rename, RS, LSB and predictor
- flush_pc  out  32  refetch PC, valid while rob_flush is high

Behaviour:
- Reset: all entries not busy; head, tail and count = 0. Every registered output is 0: register_update_flag, register_commit_dest, register_commit_value, rename_of_commit_ins, store_commit_valid, store_commit_tag, rob_flush, flush_pc.
- Entry state: busy, ready, type, rd, value, mispredict, next_pc.
- Allocate: on an edge where issue_valid && !rob_full:
  - entry[tail] gets busy = 1, ready = 0, type and rd;
  - tail increments mod ROB_SIZE.
- Full: issue_valid while rob_full is ignored. The issuer must stall. rob_full uses the registered count, so a retirement in the same cycle does not admit the issue.
- Writeback: on cdb_valid, if entry[cdb_tag] is busy, it latches value, mispredict and next_pc and sets ready = 1. A broadcast to a non-busy entry is ignored.
- Retire: each cycle, if entry[head] is busy and ready, it retires at that edge; head increments and the entry clears busy. The earliest retirement is the cycle after the CDB write, since ready is registered. Output pulses are registered, high for exactly one cycle, and otherwise 0:
  - type 0: register_update_flag = 1 with dest/value/tag; suppressed (flag 0) when rd == 0, but the entry still retires.
  - type 1: store_commit_valid = 1, store_commit_tag = head.
  - type 2 with mispredict: rob_flush = 1, flush_pc = next_pc.
  - type 2 without mispredict, and type 3: retire silently.
- Count update: count updates by +1 for an allocation, -1 for a retirement; 0 if both occur in the same cycle.
- Flush: on the edge where a mispredicted branch retires, all entries clear busy and head = tail = count = 0. In the cycle rob_flush is high, issue_valid and cdb_valid are ignored.
- Wrap-around: pointers wrap naturally at ROB_SIZE. Empty = count 0, full = count ROB_SIZE, so head == tail is unambiguous.
- rdy low: no allocation, writeback or retirement; outputs hold their values. Downstream consumers are also stalled, so a held pulse does not double-commit.
- Reset mid-operation: discards all entries in flight; outputs return to their reset values.

Optional Feature:
- Macro: ROB_QUERY_EN.
- With it: the block adds two combinational query ports, q1_tag/q2_tag (TAG_W) in and q1_ready/q1_value, q2_ready/q2_value out. These return entry ready and value, so rename can read completed-but-uncommitted operands.
  - A same-cycle CDB write to the queried tag is forwarded.
- Without it: the ports are absent, and operands are obtained only from the register file or the CDB.

Decomposition:
- Package rob_pkg holds: ROB_SIZE, TAG_W, and the type encodings ROB_T_REG, ROB_T_STORE, ROB_T_BRANCH, ROB_T_OTHER.
- One sub-module, rob_pointer_ctrl: head/tail/count registers, full/empty, and the pointer reset on flush.

Test Plan:
- Issue 3 type-0 entries (rd 5, 6, 7; tags 0, 1, 2); CDB completes tags 2, 0, 1 with values 0x22, 0x00, 0x11 -> commits in order: tags 0, 1, 2 to regs 5, 6, 7, one per cycle.
- Issue 16 entries -> rob_full = 1. A 17th issue_valid is ignored, and tail stays 0 after wrap. Retiring tag 0 clears full the following cycle.
- Branch at tag 3 completes with cdb_mispredict = 1, next_pc = 0x1040 -> when it reaches head, rob_flush = 1 and flush_pc = 0x1040 for one cycle. Younger tags 4 and 5 are never committed; count = 0 next cycle.
- Type-0 entry with rd = 0 completes -> register_update_flag stays 0 and head still advances.
- Store at tag 1 ready -> store_commit_valid = 1 with store_commit_tag = 1 for exactly one cycle.
- Hold rdy low for 3 cycles while the head is ready -> no retirement. Retirement occurs on the first edge after rdy returns high.
